// File: rtl/lim_qnt_mc.sv
// Purpose : per-channel shift/round, clamp to OUT_WIDTH, and windowed saturation statistics.
// Latency : out/valid/sat_flag 2 cycles after we; sat_cnt/stat_valid 1 cycle after the window's last valid.
// Backpressure: none; accepts one sample set per cycle on we, outputs hold while valid=0.
//
// Ports:
//   clk, resetn          clock and asynchronous active-low reset
//   we, round_en, in     sample strobe, rounding mode, CH packed signed samples
//   out, valid, sat_flag CH packed quantised samples, new-sample strobe, per-channel clamp flags
//   sat_cnt, stat_valid  per-channel clamp counts of the last window, one-cycle update pulse
module lim_qnt_mc #(
    parameter int CH          = 4,
    parameter int IN_WIDTH    = 6,
    parameter int OUT_WIDTH   = 4,
    parameter int SHIFT       = 0,
    parameter int SYMMETRICAL = 0,
    parameter int WIN_LEN     = 1024,
    parameter int CNT_W       = 16
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    we,
    input  logic                    round_en,
    input  logic [CH*IN_WIDTH-1:0]  in,
    output logic [CH*OUT_WIDTH-1:0] out,
    output logic                    valid,
    output logic [CH-1:0]           sat_flag,
    output logic [CH*CNT_W-1:0]     sat_cnt,
    output logic                    stat_valid
);

    // One extra bit so that the rounding add on the most positive input cannot wrap.
    localparam int RW = IN_WIDTH + 1;
    localparam int WW = $clog2(WIN_LEN);
    localparam logic [WW-1:0] WIN_LAST = WW'(WIN_LEN - 1);

    // Upper limit 2^(OUT_WIDTH-1)-1; ~MAXV is -2^(OUT_WIDTH-1), -MAXV the symmetric limit.
    localparam logic signed [RW-1:0] MAXV = {{(RW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [RW-1:0] LOV  = (SYMMETRICAL != 0) ? -MAXV : ~MAXV;

    // Half-LSB of the discarded bits; evaluates to 0 when SHIFT=0 so round_en has no effect.
    localparam int RND_I = (1 << SHIFT) >> 1;
    localparam logic [RW-1:0] RND = RW'(RND_I);

    logic          v1_q;
    logic [WW-1:0] win_cnt;
    logic          win_end;

    // The valid that completes a window also flushes the accumulators into sat_cnt.
    assign win_end = valid && (win_cnt == WIN_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            v1_q       <= 1'b0;
            valid      <= 1'b0;
            stat_valid <= 1'b0;
            win_cnt    <= '0;
        end else begin
            v1_q       <= we;
            valid      <= v1_q;
            stat_valid <= win_end;
            if (valid) begin
                win_cnt <= win_end ? '0 : win_cnt + 1'b1;
            end
        end
    end

    for (genvar k = 0; k < CH; k++) begin : g_ch
        logic signed [RW-1:0]  ext;
        logic signed [RW-1:0]  rsum;
        logic signed [RW-1:0]  r_d;
        logic signed [RW-1:0]  r_q;
        logic signed [RW-1:0]  c_d;
        logic                  hi_d;
        logic                  lo_d;
        logic [OUT_WIDTH-1:0]  out_q;
        logic                  flag_q;
        logic [CNT_W-1:0]      acc_q;
        logic [CNT_W-1:0]      acc_nxt;
        logic [CNT_W-1:0]      cnt_q;

        assign ext  = RW'(signed'(in[k*IN_WIDTH +: IN_WIDTH]));
        assign rsum = ext + (round_en ? RND : '0);
        assign r_d  = rsum >>> SHIFT;

        assign hi_d = (r_q > MAXV);
        assign lo_d = (r_q < LOV);
        assign c_d  = hi_d ? MAXV : (lo_d ? LOV : r_q);

        // Counter sticks at all-ones instead of wrapping.
        assign acc_nxt = (valid && flag_q && (acc_q != '1)) ? acc_q + 1'b1 : acc_q;

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                r_q    <= '0;
                out_q  <= '0;
                flag_q <= 1'b0;
                acc_q  <= '0;
                cnt_q  <= '0;
            end else begin
                if (we) begin
                    r_q <= r_d;
                end
                if (v1_q) begin
                    out_q  <= c_d[OUT_WIDTH-1:0];
                    flag_q <= hi_d || lo_d;
                end
                if (win_end) begin
                    cnt_q <= acc_nxt;
                    acc_q <= '0;
                end else begin
                    acc_q <= acc_nxt;
                end
            end
        end

        assign out[k*OUT_WIDTH +: OUT_WIDTH] = out_q;
        assign sat_flag[k]                   = flag_q;
        assign sat_cnt[k*CNT_W +: CNT_W]     = cnt_q;
    end

endmodule

// File: doc/lim_qnt_mc.md
LIM_QNT_MC -- requirements
Module: lim_qnt_mc

Interface
REQ-001 Parameter CH, default 4: number of independent channels, 1..16.
REQ-002 Parameter IN_WIDTH, default 6: signed input sample width, 3..32.
REQ-003 Parameter OUT_WIDTH, default 4: signed output sample width, 2..IN_WIDTH.
REQ-004 Parameter SHIFT, default 0: LSBs discarded before limiting, 0..IN_WIDTH-OUT_WIDTH.
REQ-005 Parameter SYMMETRICAL, default 0: 1 clamps the negative limit to -(2^(OUT_WIDTH-1)-1).
REQ-006 Parameter WIN_LEN, default 1024: output samples per statistics window, 2..2^24.
REQ-007 Parameter CNT_W, default 16: width of each saturation counter.
REQ-008 clk  input  1  single clock; all logic on its rising edge.
REQ-009 resetn  input  1  asynchronous active-low reset; reset is asynchronous and active-low.
REQ-010 we  input  1  input sample strobe for all channels.
REQ-011 round_en  input  1  1 = round half up, 0 = truncate; sampled with we.
REQ-012 in  input  CH*IN_WIDTH  signed samples; channel k at bits [k*IN_WIDTH +: IN_WIDTH].
REQ-013 out  output  CH*OUT_WIDTH  signed quantised samples; same channel packing.
REQ-014 valid  output  1  out holds a new sample set this cycle.
REQ-015 sat_flag  output  CH  per-channel flag: this out sample was clamped.
REQ-016 sat_cnt  output  CH*CNT_W  per-channel saturation count of the last completed window.
REQ-017 stat_valid  output  1  one-cycle pulse: sat_cnt updated.

Function
REQ-018 Stage 1 (registered on we): per channel r = round_en ? (in + 2^(SHIFT-1)) >>> SHIFT : in >>> SHIFT; arithmetic shift; computed in IN_WIDTH+1 bits so max positive input does not wrap; SHIFT=0 makes round_en a no-op.
REQ-019 Stage 2: clamp r to [LO, 2^(OUT_WIDTH-1)-1], LO = -2^(OUT_WIDTH-1) (SYMMETRICAL=0) or -(2^(OUT_WIDTH-1)-1) (SYMMETRICAL=1); sat_flag[k]=1 iff clamping changed the value.
REQ-020 Latency: valid asserts exactly 2 cycles after we; back-to-back we gives back-to-back valid; throughput 1 sample set/cycle.
REQ-021 out and sat_flag hold their last values while valid=0.
REQ-022 Per-channel accumulator increments on each valid with sat_flag[k]=1; saturates at 2^CNT_W-1, no wrap.
REQ-023 Window counter counts valid cycles 0..WIN_LEN-1 and wraps to 0 on the WIN_LEN-th valid.
REQ-024 The cycle after the WIN_LEN-th valid: sat_cnt <= accumulators (including that last sample), stat_valid=1 for one cycle, accumulators cleared; a valid in that same cycle counts into the new window from 0 (no sample lost or double-counted).
REQ-025 sat_cnt holds between windows; stat_valid never asserts for two consecutive cycles.
REQ-026 round_en changes take effect only for samples accepted with we in the same cycle; in-flight samples keep their mode.

Reset
REQ-027 resetn=0 asynchronously clears: pipeline registers, out=0, valid=0, sat_flag=0, sat_cnt=0, stat_valid=0, accumulators=0, window counter=0.
REQ-028 Reset mid-operation discards in-flight samples and the partial window; first valid after release is 2 cycles after the first we sampled with resetn=1.

Verification
REQ-029 IN=6, OUT=4, SHIFT=0, SYM=0, we=1, in ramp -32..31 -> out = -8 for in<=-8, in for -8..7, 7 for in>=8; sat_flag=1 exactly for in<-8 or in>7; valid 2 cycles after first we.
REQ-030 Same with SYM=1 -> in=-8 gives out=-7, sat_flag=1; in=-7 gives -7, sat_flag=0.
REQ-031 IN=6, OUT=4, SHIFT=2: in=6 -> 2 (round_en=1) / 1 (round_en=0); in=-6 -> -1 / -2; in=31, round_en=1 -> 7, sat_flag=1.
REQ-032 WIN_LEN=8, CNT_W=2, ch0 saturating on 5 of 8 samples, ch1 on 0 -> stat_valid pulse one cycle after 8th valid, sat_cnt ch0=3 (saturated), ch1=0; continuous we gives next pulse exactly 8 valids later.
REQ-033 we gaps (1 on, 2 off, repeat) -> out/sat_flag held during gaps, window counts only valid cycles.
REQ-034 resetn pulsed low for 1 cycle after 5 of WIN_LEN=8 valids -> all outputs 0 immediately; next stat_valid after 8 further valids, counts exclude pre-reset samples.
